datamemory_arbiter: RTL

- Shares one single-port data memory (registered read, positive-edge write) between two requesters, e.g. a load/store unit and a DMA/debug port.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The arbiter serialises the requests, drives the memory address/write-enable/data pins, captures the one-cycle-latency read data and returns it to the winning requester.

---
 rtl/datamemory_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/datamemory_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/datamemory_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datamemory_pkg: shared types for the two-port data memory arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package datamemory_pkg;

  localparam int NUM_REQ = 2;
  // Upper bounds for the holding record; the arbiter parameters must not exceed these.
  localparam int HOLD_AW = 32;
  localparam int HOLD_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [HOLD_AW-1:0] address;
    logic               writeEnable;
    logic [HOLD_W-1:0]  data;
    logic               grant;
  } hold_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2: combinational 2-way one-hot grant picker                 |
// | DATAMEMORY_ARBITER_FIXED_PRIO_EN selects fixed priority (req 0 wins)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef DATAMEMORY_ARBITER_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = last_grant;
  assign grant    = {valid[1] & ~valid[0], valid[0]};
`else
  always_comb begin
    grant = valid;
    // On contention the requester that did not win last time goes next.
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/datamemory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datamemory_arbiter: shares one registered-read data memory between   |
// | two valid/ready requesters. Option: DATAMEMORY_ARBITER_FIXED_PRIO_EN  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
import datamemory_pkg::*;

module datamemory_arbiter #(
  parameter int addresswidth = 32,
  parameter int width        = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [2*addresswidth-1:0]   req_address,
  input  logic [NUM_REQ-1:0]          req_writeEnable,
  input  logic [2*width-1:0]          req_dataIn,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [width-1:0]            resp_dataOut,
  output logic [addresswidth-1:0]     mem_address,
  output logic                        mem_writeEnable,
  output logic [width-1:0]            mem_dataIn,
  input  logic [width-1:0]            mem_dataOut
);

  state_t             r_state;
  hold_t              r_hold;
  logic [width-1:0]   r_resp_data;
  logic [1:0]         w_grant;
  logic               w_gidx;
  logic               w_last_grant;
  logic               w_accept;

  rr_arbiter2 u_pick (
    .valid      (req_valid),
    .last_grant (w_last_grant),
    .grant      (w_grant)
  );

  assign w_gidx   = w_grant[1];
  assign w_accept = (r_state == IDLE) && (|req_valid) && !reset;

`ifdef DATAMEMORY_ARBITER_FIXED_PRIO_EN
  assign w_last_grant = 1'b0;
`else
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_gidx;
    end
  end

  assign w_last_grant = r_last_grant;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_hold.address     <= HOLD_AW'(req_address[w_gidx*addresswidth +: addresswidth]);
            r_hold.writeEnable <= req_writeEnable[w_gidx];
            r_hold.data        <= HOLD_W'(req_dataIn[w_gidx*width +: width]);
            r_hold.grant       <= w_gidx;
            r_state            <= ACCESS;
          end
        end
        ACCESS: r_state <= CAPTURE;
        CAPTURE: begin
          // Memory output now holds the pre-write word for the held address.
          r_resp_data <= mem_dataOut;
          r_state     <= RESP;
        end
        RESP: begin
          if (resp_ready[r_hold.grant]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready       = w_accept ? w_grant : 2'b00;
  assign resp_valid      = ((r_state == RESP) && !reset) ? (r_hold.grant ? 2'b10 : 2'b01) : 2'b00;
  assign resp_dataOut    = r_resp_data;
  assign mem_address     = r_hold.address[addresswidth-1:0];
  assign mem_dataIn      = r_hold.data[width-1:0];
  assign mem_writeEnable = (r_state == ACCESS) && r_hold.writeEnable && !reset;

endmodule
`default_nettype wire
